// File: rtl/loader_pkg.sv
// Shared definitions for the byte-stream-to-RAM loader.
//
// Contents:
//   SYNC_BYTE_DEFAULT  default frame start marker (0xA5)
//   HDR_BYTES          bytes in a frame header (SYNC, ADDR_H, ADDR_L, LEN_H, LEN_L)
//   ADDR_WIDTH         RAM word address width
//   loader_state_t     frame parser states
//
// Build option: LOADER_CHECKSUM_EN adds the trailing CSUM state.
package loader_pkg;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int         HDR_BYTES         = 5;
    localparam int         ADDR_WIDTH        = 15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR_H,
        ST_ADDR_L,
        ST_LEN_H,
        ST_LEN_L,
        ST_DATA
`ifdef LOADER_CHECKSUM_EN
        ,
        ST_CSUM
`endif
    } loader_state_t;

endpackage

// File: rtl/word_assembler.sv
// Shifts bytes MSB-first into a DATA_WIDTH word and flags the byte that
// completes it.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   clear_i      drop any partial word (start of a new frame)
//   byte_en_i    a payload byte is accepted this cycle
//   byte_i       the payload byte
//   word_done_o  byte_i completes the word this cycle (combinational)
//   word_o       word including byte_i (combinational); valid with word_done_o
module word_assembler #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear_i,
    input  logic                  byte_en_i,
    input  logic [7:0]            byte_i,
    output logic                  word_done_o,
    output logic [DATA_WIDTH-1:0] word_o
);

    localparam int BPW = DATA_WIDTH / 8;
    localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;

    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] word_q, word_d;
    logic [DATA_WIDTH-1:0] shifted;
    logic                  last_byte;

    // With one byte per word there is nothing to shift; the byte is the word.
    generate
        if (BPW == 1) begin : g_single
            assign shifted = byte_i;
        end else begin : g_shift
            assign shifted = {word_q[DATA_WIDTH-9:0], byte_i};
        end
    endgenerate

    assign last_byte   = (cnt_q == CW'(BPW - 1));
    assign word_done_o = byte_en_i & last_byte & ~clear_i;
    assign word_o      = shifted;

    always_comb begin
        cnt_d  = cnt_q;
        word_d = word_q;
        if (clear_i) begin
            cnt_d  = '0;
            word_d = '0;
        end else if (byte_en_i) begin
            word_d = shifted;
            cnt_d  = last_byte ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            word_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            word_q <= word_d;
        end
    end

endmodule

// File: rtl/mem_loader.sv
// Frame parser that loads words into the data RAM over the CPU write port
// and holds the CPU off the bus while a frame is in flight.
//
// Frame: SYNC, ADDR_H, ADDR_L, LEN_H, LEN_L, LEN words (big-endian), [CSUM]
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   byte_valid/data   incoming byte link
//   byte_ready        byte accepted when byte_valid & byte_ready
//   write_m, out_m,
//   write_data_addr   single-cycle RAM write, one per word
//   hold_cpu          high while a frame is in progress
//   done / error      one-cycle frame outcome pulses
//
// Build option: LOADER_CHECKSUM_EN -- frames carry a trailing XOR checksum of
// the payload bytes; a mismatch pulses error instead of done. Without it
// error is tied low and done coincides with the last write.
module mem_loader
    import loader_pkg::*;
#(
    parameter int         DATA_WIDTH = 16,
    parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  write_m,
    output logic [DATA_WIDTH-1:0] out_m,
    output logic [14:0]           write_data_addr,
    output logic                  hold_cpu,
    output logic                  done,
    output logic                  error
);

    loader_state_t         state_q, state_d;
    logic                  ready_q;
    logic                  write_q, write_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [14:0]           waddr_q, waddr_d;
    logic                  hold_q, hold_d;
    logic                  done_q, done_d;
    logic [14:0]           addr_q, addr_d;
    logic [6:0]            addr_h_q, addr_h_d;
    logic [7:0]            len_h_q, len_h_d;
    logic [15:0]           count_q, count_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]            csum_q, csum_d;
    logic                  err_q, err_d;
`endif

    logic                  hs;
    logic                  asm_en;
    logic                  asm_clear;
    logic                  word_done;
    logic [DATA_WIDTH-1:0] word;

    assign hs        = byte_valid & ready_q;
    assign asm_en    = hs && (state_q == ST_DATA);
    assign asm_clear = hs && (state_q == ST_IDLE) && (byte_data == SYNC_BYTE);

    word_assembler #(.DATA_WIDTH(DATA_WIDTH)) u_asm (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (asm_clear),
        .byte_en_i   (asm_en),
        .byte_i      (byte_data),
        .word_done_o (word_done),
        .word_o      (word)
    );

    always_comb begin
        state_d  = state_q;
        write_d  = 1'b0;
        data_d   = data_q;
        waddr_d  = waddr_q;
        hold_d   = hold_q;
        done_d   = 1'b0;
        addr_d   = addr_q;
        addr_h_d = addr_h_q;
        len_h_d  = len_h_q;
        count_d  = count_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d   = csum_q;
        err_d    = 1'b0;
`endif
        if (hs) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (byte_data == SYNC_BYTE) begin
                        state_d = ST_ADDR_H;
                        hold_d  = 1'b1;
`ifdef LOADER_CHECKSUM_EN
                        csum_d  = '0;
`endif
                    end
                end
                ST_ADDR_H: begin
                    // Address bit 15 is dropped here.
                    addr_h_d = byte_data[6:0];
                    state_d  = ST_ADDR_L;
                end
                ST_ADDR_L: begin
                    addr_d  = {addr_h_q, byte_data};
                    state_d = ST_LEN_H;
                end
                ST_LEN_H: begin
                    len_h_d = byte_data;
                    state_d = ST_LEN_L;
                end
                ST_LEN_L: begin
                    count_d = {len_h_q, byte_data};
                    if ({len_h_q, byte_data} == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
                        state_d = ST_CSUM;
`else
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
`endif
                    end else begin
                        state_d = ST_DATA;
                    end
                end
                ST_DATA: begin
`ifdef LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ byte_data;
`endif
                    if (word_done) begin
                        write_d = 1'b1;
                        data_d  = word;
                        waddr_d = addr_q;
                        addr_d  = addr_q + 15'd1;
                        count_d = count_q - 16'd1;
                        if (count_q == 16'd1) begin
`ifdef LOADER_CHECKSUM_EN
                            state_d = ST_CSUM;
`else
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                            hold_d  = 1'b0;
`endif
                        end
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                ST_CSUM: begin
                    state_d = ST_IDLE;
                    hold_d  = 1'b0;
                    if (byte_data == csum_q) begin
                        done_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
`endif
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            ready_q  <= 1'b0;
            write_q  <= 1'b0;
            data_q   <= '0;
            waddr_q  <= '0;
            hold_q   <= 1'b0;
            done_q   <= 1'b0;
            addr_q   <= '0;
            addr_h_q <= '0;
            len_h_q  <= '0;
            count_q  <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum_q   <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            ready_q  <= 1'b1;
            write_q  <= write_d;
            data_q   <= data_d;
            waddr_q  <= waddr_d;
            hold_q   <= hold_d;
            done_q   <= done_d;
            addr_q   <= addr_d;
            addr_h_q <= addr_h_d;
            len_h_q  <= len_h_d;
            count_q  <= count_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q   <= csum_d;
            err_q    <= err_d;
`endif
        end
    end

    assign byte_ready      = ready_q;
    assign write_m         = write_q;
    assign out_m           = data_q;
    assign write_data_addr = waddr_q;
    assign hold_cpu        = hold_q;
    assign done            = done_q;
`ifdef LOADER_CHECKSUM_EN
    assign error           = err_q;
`else
    assign error           = 1'b0;
`endif

endmodule

// File: tb/tb_mem_loader.sv
// Scoreboard bench for mem_loader: the driver sends frames and pushes the
// expected writes / outcome pulses (with the cycle they must appear in) into
// queues; an independent monitor compares whatever the DUT presents.
module tb_mem_loader;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          byte_valid = 1'b0;
    logic [7:0]    byte_data = 8'h00;
    logic          byte_ready;
    logic          write_m;
    logic [DW-1:0] out_m;
    logic [14:0]   write_data_addr;
    logic          hold_cpu;
    logic          done;
    logic          error;

    mem_loader #(.DATA_WIDTH(DW)) dut (
        .clk             (clk),
        .rst             (rst),
        .byte_valid      (byte_valid),
        .byte_data       (byte_data),
        .byte_ready      (byte_ready),
        .write_m         (write_m),
        .out_m           (out_m),
        .write_data_addr (write_data_addr),
        .hold_cpu        (hold_cpu),
        .done            (done),
        .error           (error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

`ifdef LOADER_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    // kind: 0 = write, 1 = done, 2 = error
    typedef struct {
        int          kind;
        logic [14:0] addr;
        logic [15:0] data;
        int          cyc;
    } ev_t;
    typedef struct {
        int cyc;
        bit val;
    } hc_t;

    ev_t         evq[$];
    hc_t         hq[$];
    logic [15:0] wq[$];
    bit          exp_hold = 1'b0;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- monitor ----------------
    ev_t e;
    int  kind_act;
    always @(negedge clk) begin
        while (hq.size() > 0 && hq[0].cyc <= cyc) begin
            exp_hold = hq[0].val;
            void'(hq.pop_front());
        end
        chk("hold_cpu", {31'd0, hold_cpu}, {31'd0, exp_hold});

        while (evq.size() > 0 && evq[0].cyc < cyc) begin
            checks++;
            errors++;
            $display("FAIL missing_event actual=none required=kind%0d@cycle%0d", evq[0].kind, evq[0].cyc);
            void'(evq.pop_front());
        end

        if (write_m === 1'b1) begin
            if (evq.size() == 0 || evq[0].kind != 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual=addr%0h/data%0h required=no_write (cycle %0d)",
                         write_data_addr, out_m, cyc);
            end else begin
                e = evq.pop_front();
                chk("write_cycle", cyc, e.cyc);
                chk("write_addr", {17'd0, write_data_addr}, {17'd0, e.addr});
                chk("write_data", {16'd0, out_m}, {16'd0, e.data});
                $display("write addr=%04h data=%04h cycle=%0d", write_data_addr, out_m, cyc);
            end
        end

        if (done === 1'b1 || error === 1'b1) begin
            kind_act = (done && error) ? 3 : (done ? 1 : 2);
            if (evq.size() == 0 || evq[0].kind == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_end actual=kind%0d required=none (cycle %0d)", kind_act, cyc);
            end else begin
                e = evq.pop_front();
                chk("end_kind", kind_act, e.kind);
                chk("end_cycle", cyc, e.cyc);
            end
        end
    end

    // ---------------- driver ----------------
    function automatic int gap(input bit rnd);
        if (rnd && $urandom_range(0, 3) == 0) return $urandom_range(1, 3);
        return 0;
    endfunction

    task automatic send_byte(input logic [7:0] b, input int g, output int hs);
        int guard = 0;
        repeat (g) @(negedge clk);
        @(negedge clk);
        while (byte_ready !== 1'b1 && guard < 20) begin
            guard++;
            @(negedge clk);
        end
        if (byte_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL byte_ready_timeout actual=%b required=1", byte_ready);
        end
        byte_valid = 1'b1;
        byte_data  = b;
        hs         = cyc + 1;
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
        byte_data  = 8'($urandom);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_byte_ready"}, {31'd0, byte_ready}, 32'd0);
        chk({tag, "_write_m"}, {31'd0, write_m}, 32'd0);
        chk({tag, "_out_m"}, {16'd0, out_m}, 32'd0);
        chk({tag, "_addr"}, {17'd0, write_data_addr}, 32'd0);
        chk({tag, "_hold"}, {31'd0, hold_cpu}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_error"}, {31'd0, error}, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        hq.push_back('{cyc, 1'b0});
        @(negedge clk);
        check_reset_outputs("midreset");
        rst = 1'b0;
    endtask

    // Sends one frame using the words in wq and records what must come out.
    task automatic frame(input logic [15:0] a, input int len, input bit bad,
                         input bit abort, input bit rnd);
        int          hs;
        logic [7:0]  cs;
        logic [15:0] l;
        logic [15:0] w;
        logic [14:0] wa;
        cs = 8'h00;
        l  = 16'(len);
        send_byte(8'hA5, gap(rnd), hs);
        hq.push_back('{hs, 1'b1});
        send_byte(a[15:8], gap(rnd), hs);
        send_byte(a[7:0], gap(rnd), hs);
        if (abort) begin
            do_reset();
            $display("frame addr=%04h aborted by reset", a);
            return;
        end
        send_byte(l[15:8], gap(rnd), hs);
        send_byte(l[7:0], gap(rnd), hs);
        if (len == 0 && !CSUM_EN) begin
            evq.push_back('{1, 15'd0, 16'd0, hs});
            hq.push_back('{hs, 1'b0});
        end
        for (int i = 0; i < len; i++) begin
            w  = wq[i];
            wa = a[14:0] + 15'(i);
            send_byte(w[15:8], gap(rnd), hs);
            send_byte(w[7:0], gap(rnd), hs);
            cs = cs ^ w[15:8] ^ w[7:0];
            evq.push_back('{0, wa, w, hs});
            if (i == len - 1 && !CSUM_EN) begin
                evq.push_back('{1, 15'd0, 16'd0, hs});
                hq.push_back('{hs, 1'b0});
            end
        end
        if (CSUM_EN) begin
            send_byte(cs ^ {7'd0, bad}, gap(rnd), hs);
            evq.push_back('{(bad ? 2 : 1), 15'd0, 16'd0, hs});
            hq.push_back('{hs, 1'b0});
        end
        $display("frame addr=%04h len=%0d csum=%02h bad=%0d", a, len, cs, bad && CSUM_EN);
    endtask

    task automatic garbage(input int n);
        int          hs;
        logic [7:0]  b;
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            if (b == 8'hA5) b = 8'h00;
            send_byte(b, 0, hs);
        end
    endtask

    initial begin
        int          t;
        int          hs;
        logic [15:0] a;
        int          len;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Directed frames from the test plan.
        wq = '{16'h1234, 16'hABCD};
        frame(16'h0100, 2, 1'b0, 1'b0, 1'b0);
        frame(16'h0100, 2, 1'b1, 1'b0, 1'b0);
        wq = '{16'h0001, 16'h0002};
        frame(16'h7FFF, 2, 1'b0, 1'b0, 1'b0);
        wq.delete();
        frame(16'h0010, 0, 1'b0, 1'b0, 1'b0);
        send_byte(8'h00, 0, hs);
        send_byte(8'hFF, 0, hs);
        send_byte(8'h5A, 0, hs);
        wq = '{16'hA5A5, 16'h00A5};
        frame(16'h8123, 2, 1'b0, 1'b0, 1'b0);
        frame(16'h1234, 0, 1'b0, 1'b1, 1'b0);
        wq = '{16'hBEEF};
        frame(16'h0200, 1, 1'b0, 1'b0, 1'b0);

        // Randomized frames.
        for (int f = 0; f < 25; f++) begin
            garbage($urandom_range(0, 2));
            a = ($urandom_range(0, 3) == 0) ? (16'h7FFC + 16'($urandom_range(0, 3)))
                                            : 16'($urandom);
            len = $urandom_range(0, 5);
            wq.delete();
            for (int i = 0; i < len; i++) wq.push_back(16'($urandom));
            frame(a, len, ($urandom_range(0, 3) == 0), 1'b0, 1'b1);
        end

        t = 0;
        while (evq.size() > 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (evq.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d_pending required=0", evq.size());
        end
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
